inflight_wg_host_rcvr: RTL
==========================

INFLIGHT_WG_HOST_RCVR -- requirements
Module: inflight_wg_host_rcvr

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- WG_ID_WIDTH, 6, workgroup id width
- WF_COUNT_WIDTH, 4, wavefront count width
- WAVE_ITEM_WIDTH, 6, work-items in last wf
- VGPR_ID_WIDTH, 8, vgpr size field is this +1 bits
- SGPR_ID_WIDTH, 4, sgpr size field is this +1 bits
- LDS_ID_WIDTH, 8, lds size field is this +1 bits
- GDS_ID_WIDTH, 14, gds size field is this +1 bits
- MEM_ADDR_WIDTH, 32, start PC width
- FIFO_DEPTH_LOG2, 2, descriptor FIFO depth = 2**this

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all state on rising edge
- rst, in, 1, asynchronous active-low reset
- host_wg_valid, in, 1, host descriptor valid
- host_wg_id, in, WG_ID_WIDTH, workgroup id
- host_num_wf, in, WF_COUNT_WIDTH, wavefronts in WG
- host_wf_size, in, WAVE_ITEM_WIDTH, items in last wf
- host_vgpr_size_total / host_vgpr_size_per_wf, in, VGPR_ID_WIDTH+1 each, vgpr sizes
- host_sgpr_size_total / host_sgpr_size_per_wf, in, SGPR_ID_WIDTH+1 each, sgpr sizes
- host_lds_size_total, in, LDS_ID_WIDTH+1, lds size
- host_gds_size_total, in, GDS_ID_WIDTH+1, gds size
- host_start_pc, in, MEM_ADDR_WIDTH, kernel start PC
- inflight_wg_buffer_host_rcvd_ack, out, 1, one-cycle accept pulse
- inflight_wg_buffer_host_wf_done, out, 1, one-cycle WG-complete pulse
- inflight_wg_buffer_host_wf_done_wg_id, out, WG_ID_WIDTH, completed WG id
- cu_wf_done, in, 1, one wavefront finished
- cu_wf_done_wg_id, in, WG_ID_WIDTH, WG of finished wavefront
- alloc_wg_valid, out, 1, FIFO head valid
- alloc_wg_ready, in, 1, allocator consumes head
- alloc_wg_desc, out, DESC_W (=100 at defaults), MSB-first {wg_id, num_wf, wf_size, vgpr_total, sgpr_total, lds_total, gds_total, vgpr_per_wf, sgpr_per_wf, start_pc}
- err_status, out, 3, sticky: [0] num_wf zero, [1] wg id reuse, [2] done underflow

Function
REQ-003 Capture SHALL occur in cycle N iff host_wg_valid=1, FIFO not full, and rcvd_ack=0 in cycle N; the host descriptor is written to the FIFO tail at end of N.
REQ-004 rcvd_ack SHALL be a registered pulse, high exactly in cycle N+1 per capture; no capture in an ack-high cycle, so at most one capture per 2 cycles.
REQ-005 FIFO full SHALL stall capture with ack held low; host fields are held by the host and sampled unchanged later.
REQ-006 FIFO SHALL be first-word-fall-through: alloc_wg_valid=!empty; alloc_wg_desc = head; pop when alloc_wg_valid&&alloc_wg_ready.
REQ-007 Push and pop in the same cycle SHALL both take effect, including when full (pop frees the slot, so capture is allowed) and when empty (no bypass; desc is visible the next cycle).
REQ-008 Pointers SHALL wrap modulo 2**FIFO_DEPTH_LOG2; the occupancy counter SHALL be FIFO_DEPTH_LOG2+1 bits.
REQ-009 Per-WG table (2**WG_ID_WIDTH entries, WF_COUNT_WIDTH bits each) SHALL load host_num_wf at capture.
REQ-010 cu_wf_done SHALL decrement the entry; a transition 1->0 SHALL produce wf_done=1 with the wg_id in the next cycle, registered.
REQ-011 cu_wf_done to an entry already at 0 SHALL leave the entry unchanged, produce no pulse, and set err_status[2].
REQ-012 Capture with host_num_wf=0 SHALL forward the descriptor, load 0, produce no completion, and set err_status[0].
REQ-013 Capture of an id whose entry is nonzero SHALL overwrite the entry and set err_status[1].
REQ-014 Capture and cu_wf_done to the same id in the same cycle: the load SHALL win, the done SHALL be discarded, and err_status[2] SHALL be set.
REQ-015 Capture and done to different ids in the same cycle SHALL both take effect.

Reset
REQ-016 rst low SHALL asynchronously clear all outputs, FIFO pointers/count, table entries, and err_status to 0; assertion mid-transfer SHALL drop in-flight ack and done pulses.
REQ-017 After rst deasserts, capture SHALL be permitted from the first rising edge.

Verification
REQ-018 Host valid, id=5, num_wf=3, pc=0x100 -> ack in the cycle after capture; alloc_wg_desc carries id 5, pc 0x100; a second WG is captured no earlier than 2 cycles later.
REQ-019 alloc_wg_ready=0, 5 WGs offered (depth 4) -> exactly 4 acks, 5th stalls; one pop -> 5th captured and acked.
REQ-020 WG id 7, num_wf=2; two cu_wf_done id 7 -> single wf_done pulse, id 7, one cycle after the 2nd done.
REQ-021 Extra cu_wf_done id 7 after completion -> no pulse, err_status=3'b100.
REQ-022 Capture of id 9 coincident with cu_wf_done id 9 -> entry=num_wf, err_status[2]=1; capture id 9 again before completion -> err_status[1]=1.
REQ-023 rst low while FIFO holds 3 entries and an ack is pending -> outputs 0, alloc_wg_valid=0, err_status=0 immediately.

Source files
------------

// File: rtl/inflight_wg_host_rcvr.sv
// Host workgroup receiver: accepts workgroup descriptors from the host into a
// small first-word-fall-through FIFO for the allocator, and tracks outstanding
// wavefronts per workgroup so the host learns when a workgroup has completed.
module inflight_wg_host_rcvr #(
   parameter int WG_ID_WIDTH     = 6,
   parameter int WF_COUNT_WIDTH  = 4,
   parameter int WAVE_ITEM_WIDTH = 6,
   parameter int VGPR_ID_WIDTH   = 8,
   parameter int SGPR_ID_WIDTH   = 4,
   parameter int LDS_ID_WIDTH    = 8,
   parameter int GDS_ID_WIDTH    = 14,
   parameter int MEM_ADDR_WIDTH  = 32,
   parameter int FIFO_DEPTH_LOG2 = 2,
   localparam int DESC_W = WG_ID_WIDTH + WF_COUNT_WIDTH + WAVE_ITEM_WIDTH
                         + 2 * (VGPR_ID_WIDTH + 1) + 2 * (SGPR_ID_WIDTH + 1)
                         + (LDS_ID_WIDTH + 1) + (GDS_ID_WIDTH + 1) + MEM_ADDR_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       host_wg_valid,
   input  logic [WG_ID_WIDTH-1:0]     host_wg_id,
   input  logic [WF_COUNT_WIDTH-1:0]  host_num_wf,
   input  logic [WAVE_ITEM_WIDTH-1:0] host_wf_size,
   input  logic [VGPR_ID_WIDTH:0]     host_vgpr_size_total,
   input  logic [VGPR_ID_WIDTH:0]     host_vgpr_size_per_wf,
   input  logic [SGPR_ID_WIDTH:0]     host_sgpr_size_total,
   input  logic [SGPR_ID_WIDTH:0]     host_sgpr_size_per_wf,
   input  logic [LDS_ID_WIDTH:0]      host_lds_size_total,
   input  logic [GDS_ID_WIDTH:0]      host_gds_size_total,
   input  logic [MEM_ADDR_WIDTH-1:0]  host_start_pc,
   output logic                       inflight_wg_buffer_host_rcvd_ack,
   output logic                       inflight_wg_buffer_host_wf_done,
   output logic [WG_ID_WIDTH-1:0]     inflight_wg_buffer_host_wf_done_wg_id,
   input  logic                       cu_wf_done,
   input  logic [WG_ID_WIDTH-1:0]     cu_wf_done_wg_id,
   output logic                       alloc_wg_valid,
   input  logic                       alloc_wg_ready,
   output logic [DESC_W-1:0]          alloc_wg_desc,
   output logic [2:0]                 err_status
);

   localparam int unsigned DEPTH  = 1 << FIFO_DEPTH_LOG2;
   localparam int unsigned NUM_WG = 1 << WG_ID_WIDTH;

   logic [DESC_W-1:0]          fifo_q [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
   logic                       ack_q;
   logic [WF_COUNT_WIDTH-1:0]  wf_cnt_q [NUM_WG];
   logic                       done_q, done_d;
   logic [WG_ID_WIDTH-1:0]     done_id_q;
   logic [2:0]                 err_q, err_d;

   logic                       full, empty, pop, capture, collide, dec;
   logic [WF_COUNT_WIDTH-1:0]  done_entry;
   logic [DESC_W-1:0]          host_desc;

   assign host_desc = {host_wg_id, host_num_wf, host_wf_size,
                       host_vgpr_size_total, host_sgpr_size_total,
                       host_lds_size_total, host_gds_size_total,
                       host_vgpr_size_per_wf, host_sgpr_size_per_wf, host_start_pc};

   // count never exceeds DEPTH, so its MSB alone marks a full FIFO
   assign full    = count_q[FIFO_DEPTH_LOG2];
   assign empty   = (count_q == '0);
   assign pop     = !empty && alloc_wg_ready;
   assign capture = host_wg_valid && !ack_q && (!full || pop);

   assign done_entry = wf_cnt_q[cu_wf_done_wg_id];
   assign collide    = capture && (host_wg_id == cu_wf_done_wg_id);
   assign dec        = cu_wf_done && !collide && (done_entry != '0);

   // Next-state for occupancy, completion pulse and sticky error flags
   always_comb begin
      count_d = count_q;
      if (capture && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!capture && pop) begin
         count_d = count_q - 1'b1;
      end
      done_d   = dec && (done_entry == WF_COUNT_WIDTH'(1));
      err_d    = err_q;
      err_d[0] = err_q[0] | (capture && (host_num_wf == '0));
      err_d[1] = err_q[1] | (capture && (wf_cnt_q[host_wg_id] != '0));
      err_d[2] = err_q[2] | (cu_wf_done && !dec);
   end

   // Descriptor FIFO storage, pointers, occupancy and accept pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ack_q    <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         ack_q   <= capture;
         count_q <= count_d;
         if (capture) begin
            fifo_q[wr_ptr_q] <= host_desc;
            wr_ptr_q         <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   // Per-workgroup outstanding wavefront table; a same-cycle load beats a decrement
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NUM_WG; i++) begin
            wf_cnt_q[i] <= '0;
         end
      end else begin
         if (dec) begin
            wf_cnt_q[cu_wf_done_wg_id] <= done_entry - 1'b1;
         end
         if (capture) begin
            wf_cnt_q[host_wg_id] <= host_num_wf;
         end
      end
   end

   // Registered completion pulse, its workgroup id, and sticky error status
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_q    <= 1'b0;
         done_id_q <= '0;
         err_q     <= '0;
      end else begin
         done_q <= done_d;
         if (done_d) begin
            done_id_q <= cu_wf_done_wg_id;
         end
         err_q <= err_d;
      end
   end

   assign inflight_wg_buffer_host_rcvd_ack      = ack_q;
   assign inflight_wg_buffer_host_wf_done       = done_q;
   assign inflight_wg_buffer_host_wf_done_wg_id = done_id_q;
   assign alloc_wg_valid                        = !empty;
   assign alloc_wg_desc                         = fifo_q[rd_ptr_q];
   assign err_status                            = err_q;

endmodule
